// File: rtl/hs_aw_w_order_arbiter.sv
// -----------------------------------------------------------------------------
// hs_aw_w_order_arbiter
//
// Round-robin arbiter for REQ_NUM write-address (AW) requesters, paired with
// an in-order write-data (W) router. Each accepted AW is driven out through a
// single register slot and its requester index is pushed into an order FIFO.
// W beats are routed only from the requester at the FIFO head, so W bursts
// leave in exactly the order their addresses were accepted. The last beat of a
// burst pops the head.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   aw_valid_in/aw_addr_in    per-requester AW valid and packed addresses
//   aw_ready_in               one-hot grant toward the winning requester
//   aw_valid_out/aw_addr_out  granted address (register slot)
//   aw_id_out                 index of the requester that owns aw_addr_out
//   aw_ready_out              downstream AW ready
//   w_valid_in/w_data_in      per-requester W valid and packed data
//   w_last_in                 per-requester burst-last flag
//   w_ready_in                W ready, asserted only toward the FIFO head
//   w_valid_out/w_data_out    routed W beat
//   w_last_out                routed burst-last flag
//   w_ready_out               downstream W ready
//   ord_count                 order FIFO occupancy
// -----------------------------------------------------------------------------
module hs_aw_w_order_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [REQ_NUM-1:0]          aw_valid_in,
  input  logic [REQ_NUM*ADDR_W-1:0]   aw_addr_in,
  output logic [REQ_NUM-1:0]          aw_ready_in,
  output logic                        aw_valid_out,
  output logic [ADDR_W-1:0]           aw_addr_out,
  output logic [IDX_W-1:0]            aw_id_out,
  input  logic                        aw_ready_out,
  input  logic [REQ_NUM-1:0]          w_valid_in,
  input  logic [REQ_NUM*DATA_W-1:0]   w_data_in,
  input  logic [REQ_NUM-1:0]          w_last_in,
  output logic [REQ_NUM-1:0]          w_ready_in,
  output logic                        w_valid_out,
  output logic [DATA_W-1:0]           w_data_out,
  output logic                        w_last_out,
  input  logic                        w_ready_out,
  output logic [$clog2(DEPTH):0]      ord_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Arbitration state
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  // AW output slot
  logic              slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [IDX_W-1:0]  slot_id_q, slot_id_d;

  // Order FIFO
  logic [IDX_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              found;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  logic [ADDR_W-1:0] winner_addr;
  logic              slot_free;
  logic              accept;
  logic              fifo_has_room;
  logic              fifo_empty;
  logic              head_ok;
  logic [IDX_W-1:0]  head;
  logic              push;
  logic              pop;
  int                scan;

  // Rotating scan: first valid requester at or above ptr, wrapping to 0.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    scan   = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= REQ_NUM) scan = scan - REQ_NUM;
      cand = IDX_W'(scan);
      if (!found && aw_valid_in[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    winner_addr = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (winner == IDX_W'(i)) winner_addr = aw_addr_in[i*ADDR_W +: ADDR_W];
    end
  end

  // A full FIFO blocks acceptance even when the head pops this cycle; the
  // pop is not allowed to make room combinationally.
  assign slot_free     = !slot_valid_q || aw_ready_out;
  assign fifo_has_room = count_q < CNT_W'(DEPTH);
  assign accept        = rstn && slot_free && fifo_has_room && found;
  assign push          = accept;

  always_comb begin
    aw_ready_in = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      aw_ready_in[i] = accept && (winner == IDX_W'(i));
    end
  end

  // W routing from the FIFO head; gated off while empty or in reset.
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign head_ok    = rstn && !fifo_empty;

  always_comb begin
    w_valid_out = 1'b0;
    w_data_out  = '0;
    w_last_out  = 1'b0;
    w_ready_in  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (head == IDX_W'(i)) begin
        w_data_out = w_data_in[i*DATA_W +: DATA_W];
        w_last_out = w_last_in[i];
        if (head_ok) begin
          w_valid_out   = w_valid_in[i];
          w_ready_in[i] = w_ready_out;
        end
      end
    end
  end

  assign pop = w_valid_out && w_ready_out && w_last_out;

  // Next-state logic
  always_comb begin
    ptr_d        = ptr_q;
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    slot_id_d    = slot_id_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (accept) begin
      ptr_d        = (winner == IDX_W'(REQ_NUM - 1)) ? '0 : winner + IDX_W'(1);
      slot_valid_d = 1'b1;
      slot_addr_d  = winner_addr;
      slot_id_d    = winner;
    end else if (aw_ready_out) begin
      // Slot drained with nothing new behind it; address/id simply hold.
      slot_valid_d = 1'b0;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q        <= '0;
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      slot_id_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_id_q    <= slot_id_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; entries are only
  // observed through count_q, which is reset, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= winner;
  end

  assign aw_valid_out = slot_valid_q;
  assign aw_addr_out  = slot_addr_q;
  assign aw_id_out    = slot_id_q;
  assign ord_count    = count_q;

endmodule
